// File: rtl/clk_div_ctrl_pkg.sv
// Shared types and helpers for the clk_div sequencer/arbiter.
// Optional round-robin arbitration is enabled with the CLK_DIV_CTRL_RR_EN macro.
package clk_div_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        GATE,
        LOAD,
        SETTLE,
        ACK
    } ctrl_state_t;

    localparam int DEF_DIV_W = 8;

    // Wide enough to hold the larger of the two wait lengths.
    function automatic int cnt_width(input int gate_cyc, input int settle_cyc);
        int m;
        m = (gate_cyc > settle_cyc) ? gate_cyc : settle_cyc;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/req_arbiter.sv
// Combinational request arbiter: one-hot grant plus encoded index.
// CLK_DIV_CTRL_RR_EN selects round-robin from ptr; otherwise lowest index wins.
module req_arbiter
    import clk_div_ctrl_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
`ifdef CLK_DIV_CTRL_RR_EN
    input  logic [IDX_W-1:0] ptr,
`endif
    output logic             req_any,
    output logic [NREQ-1:0]  gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    assign req_any = |req;

`ifdef CLK_DIV_CTRL_RR_EN
    logic [IDX_W-1:0] sel;

    // Scan from farthest to nearest so the requester closest to ptr is kept last.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        sel     = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            sel = IDX_W'((int'(ptr) + k) % NREQ);
            if (req[sel]) begin
                gnt      = '0;
                gnt[sel] = 1'b1;
                gnt_idx  = sel;
            end
        end
    end
`else
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                gnt     = '0;
                gnt[i]  = 1'b1;
                gnt_idx = IDX_W'(i);
            end
        end
    end
`endif

endmodule

// File: rtl/clk_div_ctrl.sv
// Sequencer for the shared clk_div: gate, reprogram div_num, settle, ungate, ack.
// Define CLK_DIV_CTRL_RR_EN for round-robin arbitration (fixed priority otherwise).
module clk_div_ctrl
    import clk_div_ctrl_pkg::*;
#(
    parameter int NREQ       = 4,
    parameter int DIV_W      = DEF_DIV_W,
    parameter int GATE_CYC   = 4,
    parameter int SETTLE_CYC = 8,
    parameter int RST_DIV    = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*DIV_W-1:0] req_div,
    output logic [NREQ-1:0]       ack,
    output logic [DIV_W-1:0]      div_num,
    output logic                  clk_en,
    output logic                  busy
);

    localparam int IDX_W = $clog2(NREQ);
    localparam int CNT_W = cnt_width(GATE_CYC, SETTLE_CYC);

    ctrl_state_t      state, nxt_state;
    logic [CNT_W-1:0] cnt, nxt_cnt;

    logic             arb_any;
    logic [NREQ-1:0]  arb_gnt;
    logic [IDX_W-1:0] arb_idx;
    logic [DIV_W-1:0] slice [NREQ];
    logic [DIV_W-1:0] arb_div;

    logic [NREQ-1:0]  lat_gnt;
    logic [DIV_W-1:0] lat_div;
    logic [NREQ-1:0]  ack_gnt;

    for (genvar i = 0; i < NREQ; i++) begin : g_slice
        assign slice[i] = req_div[i*DIV_W +: DIV_W];
    end

    assign arb_div = slice[arb_idx];

`ifdef CLK_DIV_CTRL_RR_EN
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] lat_idx;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr  <= '0;
            lat_idx <= '0;
        end else begin
            if (state == IDLE && arb_any)
                lat_idx <= arb_idx;
            if (state == ACK)
                rr_ptr <= (lat_idx == IDX_W'(NREQ - 1)) ? '0 : lat_idx + 1'b1;
        end
    end
`endif

    req_arbiter #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_arb (
        .req     (req),
`ifdef CLK_DIV_CTRL_RR_EN
        .ptr     (rr_ptr),
`endif
        .req_any (arb_any),
        .gnt     (arb_gnt),
        .gnt_idx (arb_idx)
    );

    // A same-ratio request goes IDLE->ACK, before lat_gnt has been written.
    assign ack_gnt = (state == IDLE) ? arb_gnt : lat_gnt;

    always_comb begin
        nxt_state = state;
        nxt_cnt   = '0;
        case (state)
            IDLE: begin
                if (arb_any) begin
                    if (arb_div == div_num) begin
                        nxt_state = ACK;
                    end else begin
                        nxt_state = GATE;
                        nxt_cnt   = CNT_W'(GATE_CYC - 1);
                    end
                end
            end
            GATE: begin
                if (cnt == '0)
                    nxt_state = LOAD;
                else
                    nxt_cnt = cnt - 1'b1;
            end
            LOAD: begin
                nxt_state = SETTLE;
                nxt_cnt   = CNT_W'(SETTLE_CYC - 1);
            end
            SETTLE: begin
                if (cnt == '0)
                    nxt_state = ACK;
                else
                    nxt_cnt = cnt - 1'b1;
            end
            ACK:     nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            lat_gnt <= '0;
            div_num <= DIV_W'(RST_DIV);
            clk_en  <= 1'b1;
            ack     <= '0;
            busy    <= 1'b0;
        end else begin
            state  <= nxt_state;
            cnt    <= nxt_cnt;
            clk_en <= (nxt_state == IDLE) || (nxt_state == ACK);
            busy   <= (nxt_state != IDLE);
            ack    <= (nxt_state == ACK) ? ack_gnt : '0;
            if (state == IDLE && arb_any)
                lat_gnt <= arb_gnt;
            if (state == LOAD)
                div_num <= lat_div;
        end
    end

    always_ff @(posedge clk) begin
        if (state == IDLE && arb_any)
            lat_div <= arb_div;
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Bench for clk_div_ctrl: directed and random requests against a transaction-level model,
// with a behavioural clk_div and glitch-free clock gate attached to div_num/clk_en.
module tb_clk_div_ctrl;

    localparam int NREQ    = 4;
    localparam int DIV_W   = 8;
    localparam int G       = 4;
    localparam int S       = 8;
    localparam int RST_DIV = 0;
    localparam int LAT     = G + S + 2;
    localparam int IW      = $clog2(NREQ);

    logic                  clk = 1'b0;
    logic                  rst = 1'b1;
    logic [NREQ-1:0]       req = '0;
    logic [DIV_W-1:0]      rdiv [NREQ];
    logic [NREQ*DIV_W-1:0] req_div;
    logic [NREQ-1:0]       ack;
    logic [DIV_W-1:0]      div_num;
    logic                  clk_en;
    logic                  busy;

    int errors = 0;
    int checks = 0;
    int m_div  = RST_DIV;
    int m_ptr  = 0;

    for (genvar i = 0; i < NREQ; i++) begin : g_rd
        assign req_div[i*DIV_W +: DIV_W] = rdiv[i];
    end

    clk_div_ctrl #(
        .NREQ       (NREQ),
        .DIV_W      (DIV_W),
        .GATE_CYC   (G),
        .SETTLE_CYC (S),
        .RST_DIV    (RST_DIV)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .req_div (req_div),
        .ack     (ack),
        .div_num (div_num),
        .clk_en  (clk_en),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    // Divider: output toggles every div_num cycles; the gate enable is only sampled while the output is low.
    logic dclk = 1'b0;
    logic en_l = 1'b0;
    logic gclk;
    int   dcnt = 0;

    always @(posedge clk) begin
        if (div_num !== 'x && div_num != '0) begin
            if (dcnt + 1 >= int'(div_num)) begin
                dcnt <= 0;
                dclk <= ~dclk;
            end else begin
                dcnt <= dcnt + 1;
            end
        end
        if (!dclk)
            en_l <= clk_en;
    end

    assign gclk = dclk & en_l;

    logic [DIV_W-1:0] prev_div;
    logic             prev_en;
    logic             prev_rst = 1'b1;
    logic             g_prev   = 1'b0;
    int               plen     = 0;
    int               pstart   = 0;

    always @(negedge clk) begin
        if (!rst && !prev_rst && div_num !== prev_div) begin
            checks++;
            assert (clk_en === 1'b0 && prev_en === 1'b0) else begin
                errors++;
                $error("FAIL div_change_ungated: div_num %0d->%0d with clk_en %b/%b, required 0/0",
                       prev_div, div_num, prev_en, clk_en);
            end
        end
        if (gclk === 1'b1) begin
            if (!g_prev) begin
                plen   = 1;
                pstart = int'(div_num);
            end else begin
                plen++;
            end
        end else if (g_prev) begin
            checks++;
            assert (plen >= pstart) else begin
                errors++;
                $error("FAIL gated_pulse: high for %0d cycles, required at least %0d", plen, pstart);
            end
        end
        g_prev   = (gclk === 1'b1);
        prev_div = div_num;
        prev_en  = clk_en;
        prev_rst = rst;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic set_div(input logic [IW-1:0] i, input int r);
        rdiv[i] = DIV_W'(r);
    endtask

    // Winner among pending requesters: RR searches upward from the pointer, else lowest index.
    function automatic int pick(input logic [NREQ-1:0] p, input int ptr);
        int pm;
        int w;
        pm = int'(p);
        w  = -1;
        for (int k = 0; k < NREQ; k++) begin
`ifdef CLK_DIV_CTRL_RR_EN
            if (w < 0 && ((pm >> ((ptr + k) % NREQ)) & 1) == 1)
                w = (ptr + k) % NREQ;
`else
            if (w < 0 && ((pm >> k) & 1) == 1)
                w = k;
`endif
        end
        return w;
    endfunction

    // Serves pending requests one transaction at a time; the current cycle is the IDLE sampling cycle.
    task automatic serve(input int max_tx, input logic [NREQ-1:0] hold_m,
                         input logic [NREQ-1:0] drop_m, input logic [NREQ-1:0] late_m,
                         input bit scramble);
        int tx;
        tx = 0;
        while (req != '0 && tx < max_tx) begin
            int             w;
            int             r;
            int             lat;
            bit             same;
            logic [IW-1:0]  wi;
            logic [NREQ-1:0] wm;
            w    = pick(req, m_ptr);
            wi   = IW'(w);
            wm   = NREQ'(1) << wi;
            r    = int'(rdiv[wi]);
            same = (r == m_div);
            lat  = same ? 1 : LAT;
            for (int k = 1; k <= lat; k++) begin
                tick();
                check($sformatf("ack t%0d c%0d", tx, k), ack, (k == lat) ? wm : '0);
                check($sformatf("clk_en t%0d c%0d", tx, k), clk_en, (same || k == lat) ? 1 : 0);
                check($sformatf("busy t%0d c%0d", tx, k), busy, 1);
                check($sformatf("div_num t%0d c%0d", tx, k), div_num, (same || k >= G + 2) ? r : m_div);
                if (k == 1 && (drop_m & wm) != '0)
                    req = req & ~wm;
                if (k == 2 && tx == 0)
                    req = req | late_m;
                if (k == 3 && scramble)
                    rdiv[wi] = DIV_W'($urandom_range(1, 5));
            end
            m_div = r;
            m_ptr = (w + 1) % NREQ;
            tx++;
            if ((hold_m & wm) == '0)
                req = req & ~wm;
            if (tx >= max_tx)
                req = '0;
            tick();
            check("idle ack", ack, 0);
            check("idle busy", busy, 0);
            check("idle clk_en", clk_en, 1);
            check("idle div_num", div_num, m_div);
        end
    endtask

    task automatic apply_reset();
        req = '0;
        rst = 1'b1;
        repeat (2) tick();
        check("rst div_num", div_num, RST_DIV);
        rst   = 1'b0;
        m_div = RST_DIV;
        m_ptr = 0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < NREQ; i++)
            set_div(IW'(i), 0);

        // Reset held for five cycles.
        repeat (5) tick();
        check("reset div_num", div_num, RST_DIV);
        check("reset clk_en", clk_en, 1);
        check("reset busy", busy, 0);
        check("reset ack", ack, 0);
        rst = 1'b0;
        tick();
        check("post-reset busy", busy, 0);
        check("post-reset clk_en", clk_en, 1);

        // Single request, full gate/load/settle sequence.
        set_div(0, 3);
        req = 4'b0001;
        serve(1, '0, '0, '0, 1'b0);
        check("single final div", div_num, 3);

        // Same ratio again: immediate ack, no gating.
        set_div(0, 3);
        req = 4'b0001;
        serve(1, '0, '0, '0, 1'b0);

        // All four requesting with distinct ratios.
        apply_reset();
        for (int i = 0; i < NREQ; i++)
            set_div(IW'(i), i + 1);
        req = 4'b1111;
        serve(NREQ, '0, '0, '0, 1'b0);
        check("arb final div", div_num, 4);

        // req[0] held high continuously alongside the others.
        for (int i = 0; i < NREQ; i++)
            set_div(IW'(i), 2);
        req = 4'b1111;
        serve(5, 4'b0001, '0, '0, 1'b0);

        // Reset pulsed while settling.
        set_div(2, 5);
        req = 4'b0100;
        repeat (G + 4) tick();
        check("pre-abort clk_en", clk_en, 0);
        check("pre-abort div", div_num, 5);
        rst = 1'b1;
        #1;
        check("abort div_num", div_num, RST_DIV);
        check("abort clk_en", clk_en, 1);
        check("abort busy", busy, 0);
        check("abort ack", ack, 0);
        tick();
        check("abort ack held", ack, 0);
        rst   = 1'b0;
        m_div = RST_DIV;
        m_ptr = 0;
        serve(1, '0, '0, '0, 1'b0);
        check("abort retry div", div_num, 5);

        // Ratios stepped 1..5 with the divider running.
        for (int r = 1; r <= 5; r++) begin
            set_div(IW'(r % NREQ), r);
            req = NREQ'(1) << (r % NREQ);
            serve(1, '0, '0, '0, 1'b0);
        end
        check("step final div", div_num, 5);

        // Random request sets, early drops, late arrivals and post-grant ratio changes.
        for (int it = 0; it < 20; it++) begin
            logic [NREQ-1:0] m;
            logic [NREQ-1:0] late;
            logic [NREQ-1:0] drop;
            for (int i = 0; i < NREQ; i++)
                set_div(IW'(i), int'($urandom_range(1, 5)));
            m    = NREQ'($urandom_range(1, (1 << NREQ) - 1));
            late = NREQ'($urandom) & ~m;
            drop = NREQ'($urandom);
            req  = m;
            serve(16, '0, drop, late, 1'b1);
            check($sformatf("rand%0d settled busy", it), busy, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
